// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and interrupt controller:
// CSR addresses, operation/state encodings, mstatus bit positions, cause codes.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP_REQ = 2'd1,
    ST_MRET_REQ = 2'd2
  } irq_state_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [4:0] CAUSE_MEI        = 5'd11;
  localparam logic [4:0] CAUSE_MTI        = 5'd7;
  localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;

  function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: csr_apply_op = wdata;
      CSR_OP_SET:   csr_apply_op = old_val | wdata;
      CSR_OP_CLEAR: csr_apply_op = old_val & ~wdata;
      default:      csr_apply_op = old_val;
    endcase
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder: MEI > MTI > local lines (lowest index first).
// Pending vector packing: bit 0 = MEI, bit 1 = MTI, bit 2+i = local line i.
module irq_prio_enc
  import csr_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4
) (
  input  logic [NUM_LOCAL_IRQ+1:0] i_pending,
  output logic                     o_any,
  output logic [4:0]               o_cause
);

  always_comb begin
    o_any   = 1'b0;
    o_cause = 5'd0;
    // Walk from the weakest source upward so stronger sources overwrite.
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
      if (i_pending[2+i]) begin
        o_any   = 1'b1;
        o_cause = CAUSE_LOCAL_BASE + 5'(i);
      end
    end
    if (i_pending[1]) begin
      o_any   = 1'b1;
      o_cause = CAUSE_MTI;
    end
    if (i_pending[0]) begin
      o_any   = 1'b1;
      o_cause = CAUSE_MEI;
    end
  end

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file plus interrupt/mret redirect controller for the 3-stage core.
// Redirect handshake: o_trap_req is raised with a stable o_trap_pc and held until i_redirect_ack.
module csr_irq_unit
  import csr_pkg::*;
#(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [11:0]              i_csr_addr,
  input  logic [1:0]               i_csr_op,
  input  logic                     i_csr_en,
  input  logic [31:0]              i_csr_wdata,
  output logic [31:0]              o_csr_rdata,
  output logic                     o_csr_illegal,
  input  logic [31:0]              i_instr_pc,
  input  logic                     i_pc_valid,
  input  logic                     i_mret,
  input  logic                     i_timer_irq,
  input  logic                     i_ext_irq,
  input  logic [NUM_LOCAL_IRQ-1:0] i_local_irq,
  output logic                     o_trap_req,
  output logic [31:0]              o_trap_pc,
  input  logic                     i_redirect_ack,
  output logic [1:0]               o_dbg_state
);

  localparam logic [31:0] MIE_MASK =
    32'h0000_0880 | (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16);

  irq_state_e               r_state;
  logic                     r_trap_req;
  logic [31:0]              r_trap_pc;
  logic                     r_mstatus_mie;
  logic                     r_mstatus_mpie;
  logic [31:0]              r_mie;
  logic [31:0]              r_mtvec;
  logic [31:0]              r_mscratch;
  logic [31:0]              r_mepc;
  logic [31:0]              r_mcause;
  logic [31:0]              r_mcycle;
  logic                     r_mip_mei;
  logic                     r_mip_mti;
  logic [NUM_LOCAL_IRQ-1:0] r_mip_local;

  logic [31:0]              w_mstatus;
  logic [31:0]              w_mip;
  logic                     w_addr_valid;
  logic [31:0]              w_rdata;
  logic [31:0]              w_new;
  logic                     w_wr_active;
  logic [NUM_LOCAL_IRQ+1:0] w_pending;
  logic                     w_irq_any;
  logic [4:0]               w_cause;
  logic                     w_take_trap;
  logic                     w_take_mret;
  logic [31:0]              w_vec_pc;
  csr_op_e                  w_op;

  assign w_op = csr_op_e'(i_csr_op);

  always_comb begin
    w_mstatus                   = 32'h0000_1800;
    w_mstatus[MSTATUS_MIE]      = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE]     = r_mstatus_mpie;
    w_mip                       = 32'h0;
    w_mip[11]                   = r_mip_mei;
    w_mip[7]                    = r_mip_mti;
    w_mip[16 +: NUM_LOCAL_IRQ]  = r_mip_local;
  end

  always_comb begin
    w_addr_valid = 1'b1;
    w_rdata      = 32'h0;
    case (i_csr_addr)
      CSR_MSTATUS:  w_rdata = w_mstatus;
      CSR_MIE:      w_rdata = r_mie;
      CSR_MTVEC:    w_rdata = r_mtvec;
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = r_mepc;
      CSR_MCAUSE:   w_rdata = r_mcause;
      CSR_MIP:      w_rdata = w_mip;
      CSR_MCYCLE:   w_rdata = r_mcycle;
      default:      w_addr_valid = 1'b0;
    endcase
  end

  assign o_csr_rdata   = w_rdata;
  assign o_csr_illegal = i_csr_en && !w_addr_valid;
  assign w_new         = csr_apply_op(w_op, w_rdata, i_csr_wdata);

  assign w_pending = {r_mip_local & r_mie[16 +: NUM_LOCAL_IRQ],
                      r_mip_mti & r_mie[7],
                      r_mip_mei & r_mie[11]} & {(NUM_LOCAL_IRQ + 2){r_mstatus_mie}};

  irq_prio_enc #(
    .NUM_LOCAL_IRQ (NUM_LOCAL_IRQ)
  ) u_prio (
    .i_pending (w_pending),
    .o_any     (w_irq_any),
    .o_cause   (w_cause)
  );

  assign w_take_mret = (r_state == ST_IDLE) && i_mret;
  assign w_take_trap = (r_state == ST_IDLE) && !i_mret && w_irq_any && i_pc_valid;
  assign w_vec_pc    = {r_mtvec[31:2], 2'b00} +
                       ((r_mtvec[1:0] == 2'b01) ? {25'b0, w_cause, 2'b00} : 32'h0);

  // Set/clear with a zero operand is a pure read; leaving IDLE squashes the write
  // because the interrupted instruction will re-execute.
  assign w_wr_active = i_csr_en && w_addr_valid && (r_state == ST_IDLE) &&
                       !w_take_trap && !w_take_mret &&
                       ((w_op == CSR_OP_WRITE) ||
                        (((w_op == CSR_OP_SET) || (w_op == CSR_OP_CLEAR)) &&
                         (i_csr_wdata != 32'h0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 32'h0;
      r_mtvec        <= RESET_MTVEC;
      r_mscratch     <= 32'h0;
      r_mepc         <= 32'h0;
      r_mcause       <= 32'h0;
      r_mcycle       <= 32'h0;
      r_mip_mei      <= 1'b0;
      r_mip_mti      <= 1'b0;
      r_mip_local    <= '0;
    end else begin
      r_mip_mei   <= i_ext_irq;
      r_mip_mti   <= i_timer_irq;
      r_mip_local <= i_local_irq;
      if (w_wr_active && (i_csr_addr == CSR_MCYCLE)) r_mcycle <= w_new;
      else                                           r_mcycle <= r_mcycle + 32'h1;
      if (w_take_trap) begin
        r_mepc         <= {i_instr_pc[31:2], 2'b00};
        r_mcause       <= {1'b1, 26'b0, w_cause};
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (w_take_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wr_active) begin
        case (i_csr_addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= w_new[MSTATUS_MIE];
            r_mstatus_mpie <= w_new[MSTATUS_MPIE];
          end
          CSR_MIE:      r_mie      <= w_new & MIE_MASK;
          CSR_MTVEC:    r_mtvec    <= {w_new[31:2], (w_new[1] ? 2'b00 : w_new[1:0])};
          CSR_MSCRATCH: r_mscratch <= w_new;
          CSR_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
          CSR_MCAUSE:   r_mcause   <= w_new;
          default:      ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_trap_req <= 1'b0;
      r_trap_pc  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_mret) begin
            r_state    <= ST_MRET_REQ;
            r_trap_req <= 1'b1;
            r_trap_pc  <= r_mepc;
          end else if (w_take_trap) begin
            r_state    <= ST_TRAP_REQ;
            r_trap_req <= 1'b1;
            r_trap_pc  <= w_vec_pc;
          end
        end
        ST_TRAP_REQ, ST_MRET_REQ: begin
          if (i_redirect_ack) begin
            r_state    <= ST_IDLE;
            r_trap_req <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_trap_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_trap_req  = r_trap_req;
  assign o_trap_pc   = r_trap_pc;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_csr_irq_unit.sv
// Directed testbench for csr_irq_unit: CSR access, trap/mret redirects, priority,
// handshake hold, reset drop and mcycle wrap, with hand-computed expectations.
module tb_csr_irq_unit;

  localparam int          N_LOC  = 4;
  localparam logic [31:0] RST_TV = 32'h0000_0080;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [1:0]  OP_W = 2'b01, OP_S = 2'b10, OP_C = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic [11:0]      csr_addr;
  logic [1:0]       csr_op;
  logic             csr_en;
  logic [31:0]      csr_wdata;
  logic [31:0]      csr_rdata;
  logic             csr_illegal;
  logic [31:0]      instr_pc;
  logic             pc_valid;
  logic             mret;
  logic             timer_irq;
  logic             ext_irq;
  logic [N_LOC-1:0] local_irq;
  logic             trap_req;
  logic [31:0]      trap_pc;
  logic             redirect_ack;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  csr_irq_unit #(
    .NUM_LOCAL_IRQ (N_LOC),
    .RESET_MTVEC   (RST_TV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_csr_addr     (csr_addr),
    .i_csr_op       (csr_op),
    .i_csr_en       (csr_en),
    .i_csr_wdata    (csr_wdata),
    .o_csr_rdata    (csr_rdata),
    .o_csr_illegal  (csr_illegal),
    .i_instr_pc     (instr_pc),
    .i_pc_valid     (pc_valid),
    .i_mret         (mret),
    .i_timer_irq    (timer_irq),
    .i_ext_irq      (ext_irq),
    .i_local_irq    (local_irq),
    .o_trap_req     (trap_req),
    .o_trap_pc      (trap_pc),
    .i_redirect_ack (redirect_ack),
    .o_dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic csr_rd(input logic [11:0] addr, output logic [31:0] data);
    csr_addr = addr;
    csr_op   = 2'b00;
    csr_en   = 1'b1;
    #1;
    data   = csr_rdata;
    csr_en = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
    csr_addr  = addr;
    csr_op    = op;
    csr_wdata = data;
    csr_en    = 1'b1;
    tick();
    csr_en    = 1'b0;
    csr_op    = 2'b00;
    csr_wdata = 32'h0;
  endtask

  task automatic ack();
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
  endtask

  task automatic expect_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    csr_rd(addr, v);
    check(tag, v, exp);
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; csr_addr = '0; csr_op = '0; csr_en = 1'b0; csr_wdata = '0;
    instr_pc = 32'h40; pc_valid = 1'b0; mret = 1'b0; timer_irq = 1'b0;
    ext_irq = 1'b0; local_irq = '0; redirect_ack = 1'b0;
    tick(); tick();

    // 1: reset values (reset still held so mcycle is frozen at 0)
    expect_csr("rst_mstatus", A_MSTATUS, 32'h0000_1800);
    expect_csr("rst_mie", A_MIE, 32'h0);
    expect_csr("rst_mtvec", A_MTVEC, RST_TV);
    expect_csr("rst_mscratch", A_MSCRATCH, 32'h0);
    expect_csr("rst_mepc", A_MEPC, 32'h0);
    expect_csr("rst_mcause", A_MCAUSE, 32'h0);
    expect_csr("rst_mip", A_MIP, 32'h0);
    expect_csr("rst_mcycle", A_MCYCLE, 32'h0);
    check("rst_trap_req", {31'b0, trap_req}, 32'h0);
    check("rst_trap_pc", trap_pc, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'h0);
    csr_addr = 12'h7C0; csr_en = 1'b1; #1;
    check("illegal_flag", {31'b0, csr_illegal}, 32'h1);
    check("illegal_rdata", csr_rdata, 32'h0);
    csr_en = 1'b0; #1;
    check("noen_illegal", {31'b0, csr_illegal}, 32'h0);
    csr_addr = A_MIP; csr_en = 1'b1; #1;
    check("mip_not_illegal", {31'b0, csr_illegal}, 32'h0);
    csr_en = 1'b0;
    reset = 1'b0;
    tick();

    // 2: external interrupt, direct mode
    csr_wr(A_MTVEC, OP_W, 32'h100);
    csr_wr(A_MIE, OP_W, 32'h800);
    csr_wr(A_MSTATUS, OP_S, 32'h8);
    pc_valid = 1'b1;
    ext_irq  = 1'b1;
    tick();
    check("mei_lat1_req", {31'b0, trap_req}, 32'h0);
    expect_csr("mei_mip", A_MIP, 32'h800);
    tick();
    check("mei_req", {31'b0, trap_req}, 32'h1);
    check("mei_pc", trap_pc, 32'h100);
    check("mei_state", {30'b0, dbg_state}, 32'h1);
    expect_csr("mei_mepc", A_MEPC, 32'h40);
    expect_csr("mei_mcause", A_MCAUSE, 32'h8000_000B);
    expect_csr("mei_mstatus", A_MSTATUS, 32'h0000_1880);
    ack();
    check("mei_ack_req", {31'b0, trap_req}, 32'h0);

    // 4: mret with ext_irq still high; retrap only after return to IDLE
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("mret_req", {31'b0, trap_req}, 32'h1);
    check("mret_pc", trap_pc, 32'h40);
    expect_csr("mret_mstatus", A_MSTATUS, 32'h0000_1888);
    tick(); tick();
    check("mret_hold_state", {30'b0, dbg_state}, 32'h2);
    check("mret_hold_pc", trap_pc, 32'h40);
    ack();
    check("mret_ack_req", {31'b0, trap_req}, 32'h0);
    tick();
    check("retrap_req", {31'b0, trap_req}, 32'h1);
    check("retrap_pc", trap_pc, 32'h100);
    ack();
    ext_irq = 1'b0;

    // 3: vectored mode, MTI beats local[2], then local[2] alone
    csr_wr(A_MTVEC, OP_W, 32'h201);
    csr_wr(A_MIE, OP_W, 32'h0004_0080);
    timer_irq = 1'b1;
    local_irq = 4'b0100;
    tick();
    csr_wr(A_MSTATUS, OP_S, 32'h8);
    check("vec_lat_req", {31'b0, trap_req}, 32'h0);
    tick();
    check("mti_req", {31'b0, trap_req}, 32'h1);
    check("mti_pc", trap_pc, 32'h21C);
    expect_csr("mti_mcause", A_MCAUSE, 32'h8000_0007);
    ack();
    csr_wr(A_MIE, OP_C, 32'h80);
    csr_wr(A_MSTATUS, OP_S, 32'h8);
    tick();
    check("loc_req", {31'b0, trap_req}, 32'h1);
    check("loc_pc", trap_pc, 32'h248);
    expect_csr("loc_mcause", A_MCAUSE, 32'h8000_0012);
    ack();
    timer_irq = 1'b0;
    local_irq = '0;
    tick();

    // 5: set/clear semantics, WARL fields, read-only mip
    csr_wr(A_MSCRATCH, OP_W, 32'hF0);
    csr_wr(A_MSCRATCH, OP_S, 32'h0F);
    expect_csr("scr_set", A_MSCRATCH, 32'hFF);
    csr_wr(A_MSCRATCH, OP_C, 32'h0F);
    expect_csr("scr_clr", A_MSCRATCH, 32'hF0);
    csr_wr(A_MTVEC, OP_W, 32'h302);
    expect_csr("mtvec_mode", A_MTVEC, 32'h300);
    csr_wr(A_MEPC, OP_W, 32'h43);
    expect_csr("mepc_align", A_MEPC, 32'h40);
    csr_wr(A_MIE, OP_W, 32'hFFFF_FFFF);
    expect_csr("mie_mask", A_MIE, 32'h000F_0880);
    csr_wr(A_MIP, OP_W, 32'hFFFF_FFFF);
    expect_csr("mip_ro", A_MIP, 32'h0);

    // 6: held handshake, writes ignored, reset drop, mcycle wrap
    csr_wr(A_MIE, OP_W, 32'h800);
    ext_irq = 1'b1;
    tick();
    csr_wr(A_MSTATUS, OP_S, 32'h8);
    tick();
    check("hold_req0", {31'b0, trap_req}, 32'h1);
    check("hold_pc0", trap_pc, 32'h300);
    for (int i = 0; i < 5; i++) begin
      csr_wr(A_MSCRATCH, OP_W, 32'h1234);
      check($sformatf("hold_req%0d", i + 1), {31'b0, trap_req}, 32'h1);
      check($sformatf("hold_pc%0d", i + 1), trap_pc, 32'h300);
    end
    expect_csr("hold_scr", A_MSCRATCH, 32'hF0);
    reset = 1'b1;
    tick();
    check("rstmid_req", {31'b0, trap_req}, 32'h0);
    check("rstmid_state", {30'b0, dbg_state}, 32'h0);
    reset   = 1'b0;
    ext_irq = 1'b0;
    tick();
    csr_wr(A_MCYCLE, OP_W, 32'hFFFF_FFFF);
    expect_csr("mcycle_wr", A_MCYCLE, 32'hFFFF_FFFF);
    tick();
    expect_csr("mcycle_wrap", A_MCYCLE, 32'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
